// File: rtl/xcvr_rx_lock_sequencer_if.sv
// Control/status bundle between the RX lock sequencer and its user.
// Master drives the lock inputs and controls; slave is the sequencer.
interface xcvr_rx_lock_sequencer_if;
    logic       EN;
    logic       PLL_LOCK_I;
    logic       CDR_LOCK_I;
    logic       RX_VAL_I;
    logic       CLR_FAULT;
    logic       RX_PCS_RESET_N;
    logic       RX_READY;
    logic       LOSS_OF_LOCK;
    logic [2:0] RETRY_CNT;
    logic       FAULT;
    logic [2:0] STATE;

    modport master (
        output EN, PLL_LOCK_I, CDR_LOCK_I, RX_VAL_I, CLR_FAULT,
        input  RX_PCS_RESET_N, RX_READY, LOSS_OF_LOCK,
        input  RETRY_CNT, FAULT, STATE
    );

    modport slave (
        input  EN, PLL_LOCK_I, CDR_LOCK_I, RX_VAL_I, CLR_FAULT,
        output RX_PCS_RESET_N, RX_READY, LOSS_OF_LOCK,
        output RETRY_CNT, FAULT, STATE
    );
endinterface

// File: rtl/xcvr_rx_lock_sequencer.sv
// RX PCS reset sequencer: synchronises lock indications, qualifies
// link-up with a stable-hold window, retries on timeout, latches a fault.
module xcvr_rx_lock_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int HOLD_CYCLES    = 1024,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int RST_CYCLES     = 16,
    parameter int MAX_RETRY      = 7,
    parameter int CNT_W          = 17
) (
    input  logic                     CLK,
    input  logic                     RESETN,
    xcvr_rx_lock_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_RESET_HOLD = 3'd0,
        S_WAIT_PLL   = 3'd1,
        S_WAIT_CDR   = 3'd2,
        S_QUALIFY    = 3'd3,
        S_READY      = 3'd4,
        S_FAULT      = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]       RETRY_MAX = 3'(MAX_RETRY);

    logic [SYNC_STAGES-1:0] pll_sync;
    logic [SYNC_STAGES-1:0] cdr_sync;
    logic [SYNC_STAGES-1:0] val_sync;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             rst_n_q;
    logic             ready_q;
    logic             lol_q;
    logic [2:0]       retry_q;
    logic             fault_q;

    logic pll;
    logic cdr;
    logic val;
    logic all_lock;
    logic to_hit;
    logic retry_req;

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            pll_sync <= '0;
            cdr_sync <= '0;
            val_sync <= '0;
        end else begin
            pll_sync <= {pll_sync[SYNC_STAGES-2:0], bus.PLL_LOCK_I};
            cdr_sync <= {cdr_sync[SYNC_STAGES-2:0], bus.CDR_LOCK_I};
            val_sync <= {val_sync[SYNC_STAGES-2:0], bus.RX_VAL_I};
        end
    end

    assign pll      = pll_sync[SYNC_STAGES-1];
    assign cdr      = cdr_sync[SYNC_STAGES-1];
    assign val      = val_sync[SYNC_STAGES-1];
    assign all_lock = pll & cdr & val;
    assign cnt_inc  = (&cnt) ? cnt : cnt + 1'b1;
    assign to_hit   = (cnt == TO_LAST);

    // Losing the PLL while waiting for CDR counts as a failed attempt.
    assign retry_req =
        (state == S_WAIT_PLL && !pll && to_hit) ||
        (state == S_WAIT_CDR && (!pll || (!(cdr && val) && to_hit)));

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state   <= S_RESET_HOLD;
            cnt     <= '0;
            rst_n_q <= 1'b0;
            ready_q <= 1'b0;
            lol_q   <= 1'b0;
            retry_q <= '0;
            fault_q <= 1'b0;
        end else begin
            lol_q <= 1'b0;
            cnt   <= cnt_inc;
            if (!bus.EN && state != S_FAULT) begin
                state   <= S_RESET_HOLD;
                cnt     <= '0;
                rst_n_q <= 1'b0;
                ready_q <= 1'b0;
            end else if (retry_req) begin
                cnt     <= '0;
                rst_n_q <= 1'b0;
                if (retry_q == RETRY_MAX) begin
                    state   <= S_FAULT;
                    fault_q <= 1'b1;
                end else begin
                    state   <= S_RESET_HOLD;
                    retry_q <= retry_q + 1'b1;
                end
            end else begin
                unique case (state)
                    S_RESET_HOLD: begin
                        if (cnt == RST_LAST) begin
                            state <= S_WAIT_PLL;
                            cnt   <= '0;
                        end
                    end
                    S_WAIT_PLL: begin
                        if (pll) begin
                            state   <= S_WAIT_CDR;
                            cnt     <= '0;
                            rst_n_q <= 1'b1;
                        end
                    end
                    S_WAIT_CDR: begin
                        if (cdr && val) begin
                            state <= S_QUALIFY;
                            cnt   <= '0;
                        end
                    end
                    S_QUALIFY: begin
                        if (!all_lock) begin
                            state <= S_WAIT_CDR;
                            cnt   <= '0;
                        end else if (cnt == HOLD_LAST) begin
                            state   <= S_READY;
                            cnt     <= '0;
                            ready_q <= 1'b1;
                            retry_q <= '0;
                        end
                    end
                    S_READY: begin
                        if (!all_lock) begin
                            state   <= S_RESET_HOLD;
                            cnt     <= '0;
                            ready_q <= 1'b0;
                            rst_n_q <= 1'b0;
                            lol_q   <= 1'b1;
                        end
                    end
                    S_FAULT: begin
                        if (bus.CLR_FAULT) begin
                            state   <= S_RESET_HOLD;
                            cnt     <= '0;
                            fault_q <= 1'b0;
                            retry_q <= '0;
                        end
                    end
                    default: begin
                        state   <= S_RESET_HOLD;
                        cnt     <= '0;
                        rst_n_q <= 1'b0;
                        ready_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.RX_PCS_RESET_N = rst_n_q;
    assign bus.RX_READY       = ready_q;
    assign bus.LOSS_OF_LOCK   = lol_q;
    assign bus.RETRY_CNT      = retry_q;
    assign bus.FAULT          = fault_q;
    assign bus.STATE          = state;

endmodule

// File: tb/tb_xcvr_rx_lock_sequencer.sv
// Bench for xcvr_rx_lock_sequencer: directed bring-up scenarios plus
// random lock/enable/reset segments against a timestamp-based model.
module tb_xcvr_rx_lock_sequencer;

    localparam int SYNC = 2;
    localparam int HOLD = 200;
    localparam int TO   = 64;
    localparam int RSTC = 16;
    localparam int MAXR = 7;
    localparam int CW   = 17;

    localparam int ST_HOLD  = 0;
    localparam int ST_PLL   = 1;
    localparam int ST_CDR   = 2;
    localparam int ST_QUAL  = 3;
    localparam int ST_READY = 4;
    localparam int ST_FAULT = 5;

    logic CLK;
    logic RESETN;

    xcvr_rx_lock_sequencer_if bus();

    xcvr_rx_lock_sequencer #(
        .SYNC_STAGES    (SYNC),
        .HOLD_CYCLES    (HOLD),
        .TIMEOUT_CYCLES (TO),
        .RST_CYCLES     (RSTC),
        .MAX_RETRY      (MAXR),
        .CNT_W          (CW)
    ) u_dut (
        .CLK    (CLK),
        .RESETN (RESETN),
        .bus    (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference: phase plus the cycle at which its timer started.
    int         m_st    = ST_HOLD;
    int         m_tent  = 1;
    int         m_retry = 0;
    bit         m_fault = 1'b0;
    bit         m_lol   = 1'b0;
    logic [2:0] sq[$];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     tag, obs, exp, cyc);
        end
    endtask

    task automatic enter(int s);
        m_st   = s;
        m_tent = cyc + 1;
    endtask

    task automatic attempt_failed();
        if (m_retry == MAXR) begin
            m_fault = 1'b1;
            enter(ST_FAULT);
        end else begin
            m_retry++;
            enter(ST_HOLD);
        end
    endtask

    task automatic model_step();
        logic [2:0] seen;
        bit p, c, v;
        int el;
        cyc++;
        m_lol = 1'b0;
        if (!RESETN) begin
            sq.delete();
            repeat (SYNC) sq.push_back(3'b000);
            m_retry = 0;
            m_fault = 1'b0;
            enter(ST_HOLD);
            return;
        end
        seen = sq.pop_front();
        sq.push_back({bus.PLL_LOCK_I, bus.CDR_LOCK_I, bus.RX_VAL_I});
        p  = seen[2];
        c  = seen[1];
        v  = seen[0];
        el = cyc - m_tent;
        if (!bus.EN && m_st != ST_FAULT) begin
            enter(ST_HOLD);
        end else begin
            case (m_st)
                ST_HOLD:  if (el == RSTC - 1) enter(ST_PLL);
                ST_PLL: begin
                    if (p) enter(ST_CDR);
                    else if (el == TO - 1) attempt_failed();
                end
                ST_CDR: begin
                    if (!p) attempt_failed();
                    else if (c && v) enter(ST_QUAL);
                    else if (el == TO - 1) attempt_failed();
                end
                ST_QUAL: begin
                    if (!(p && c && v)) enter(ST_CDR);
                    else if (el == HOLD - 1) begin
                        m_retry = 0;
                        enter(ST_READY);
                    end
                end
                ST_READY: begin
                    if (!(p && c && v)) begin
                        m_lol = 1'b1;
                        enter(ST_HOLD);
                    end
                end
                ST_FAULT: begin
                    if (bus.CLR_FAULT) begin
                        m_fault = 1'b0;
                        m_retry = 0;
                        enter(ST_HOLD);
                    end
                end
                default: enter(ST_HOLD);
            endcase
        end
    endtask

    task automatic compare_all();
        bit rel;
        rel = (m_st == ST_CDR) || (m_st == ST_QUAL) || (m_st == ST_READY);
        chk("state", 32'(bus.STATE), 32'(m_st));
        chk("rx_pcs_reset_n", 32'(bus.RX_PCS_RESET_N), 32'(rel));
        chk("rx_ready", 32'(bus.RX_READY), 32'(m_st == ST_READY));
        chk("loss_of_lock", 32'(bus.LOSS_OF_LOCK), 32'(m_lol));
        chk("retry_cnt", 32'(bus.RETRY_CNT), 32'(m_retry));
        chk("fault", 32'(bus.FAULT), 32'(m_fault));
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        compare_all();
    endtask

    task automatic run(int n);
        repeat (n) tick();
    endtask

    task automatic locks(bit p, bit c, bit v);
        bus.PLL_LOCK_I = p;
        bus.CDR_LOCK_I = c;
        bus.RX_VAL_I   = v;
    endtask

    task automatic wait_state(int s, int budget, string tag, output int n);
        n = 0;
        while (32'(bus.STATE) != 32'(s) && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(bus.STATE), 32'(s));
    endtask

    int n;
    int pulses;
    int rsv;
    int last;
    bit steps_ok;

    initial begin
        RESETN = 1'b0;
        bus.EN = 1'b0;
        bus.CLR_FAULT = 1'b0;
        locks(0, 0, 0);
        @(negedge CLK);

        // Reset state
        run(5);
        chk("reset_state", 32'(bus.STATE), 32'd0);
        chk("reset_rstn", 32'(bus.RX_PCS_RESET_N), 32'd0);

        // Nominal bring-up
        RESETN = 1'b1;
        bus.EN = 1'b1;
        run($urandom_range(20, 40));
        locks(1, 0, 0);
        run($urandom_range(20, 45));
        locks(1, 1, 1);
        wait_state(ST_READY, HOLD + 300, "nominal_ready_state", n);
        chk("nominal_hold_len", 32'(n >= HOLD), 32'd1);
        tick();
        chk("nominal_ready", 32'(bus.RX_READY), 32'd1);
        chk("nominal_retry", 32'(bus.RETRY_CNT), 32'd0);

        // EN dropped mid-QUALIFY
        bus.EN = 1'b0;
        tick();
        bus.EN = 1'b1;
        wait_state(ST_QUAL, 200, "reach_qualify", n);
        run(30);
        rsv = 32'(bus.RETRY_CNT);
        bus.EN = 1'b0;
        tick();
        chk("en_state", 32'(bus.STATE), 32'd0);
        chk("en_rstn", 32'(bus.RX_PCS_RESET_N), 32'd0);
        chk("en_lol", 32'(bus.LOSS_OF_LOCK), 32'd0);
        chk("en_retry", 32'(bus.RETRY_CNT), 32'(rsv));
        bus.EN = 1'b1;

        // Qualify glitch restarts the hold window
        wait_state(ST_QUAL, 200, "reach_qualify2", n);
        run($urandom_range(50, 150));
        bus.CDR_LOCK_I = 1'b0;
        run(3);
        bus.CDR_LOCK_I = 1'b1;
        chk("glitch_state", 32'(bus.STATE), 32'(ST_CDR));
        chk("glitch_retry", 32'(bus.RETRY_CNT), 32'(rsv));
        wait_state(ST_QUAL, 50, "glitch_requalify", n);
        wait_state(ST_READY, HOLD + 50, "glitch_ready", n);
        chk("glitch_hold_len", 32'(n >= HOLD - 1), 32'd1);

        // Lock loss in READY
        bus.PLL_LOCK_I = 1'b0;
        pulses = 0;
        repeat (SYNC + 2) begin
            tick();
            pulses += 32'(bus.LOSS_OF_LOCK);
        end
        chk("lol_ready", 32'(bus.RX_READY), 32'd0);
        chk("lol_rstn", 32'(bus.RX_PCS_RESET_N), 32'd0);
        chk("lol_state", 32'(bus.STATE), 32'd0);
        repeat (3) begin
            tick();
            pulses += 32'(bus.LOSS_OF_LOCK);
        end
        chk("lol_pulses", 32'(pulses), 32'd1);

        // Timeout retries then FAULT, PLL held low
        last = 32'(bus.RETRY_CNT);
        steps_ok = 1'b1;
        n = 0;
        while (!bus.FAULT && n < 1200) begin
            tick();
            n++;
            if (32'(bus.RETRY_CNT) != last) begin
                if (32'(bus.RETRY_CNT) != last + 1) steps_ok = 1'b0;
                last = 32'(bus.RETRY_CNT);
            end
        end
        chk("retry_steps", 32'(steps_ok), 32'd1);
        chk("fault_set", 32'(bus.FAULT), 32'd1);
        chk("fault_state", 32'(bus.STATE), 32'(ST_FAULT));
        chk("fault_retry", 32'(bus.RETRY_CNT), 32'(MAXR));
        bus.EN = 1'b0;
        run(3);
        chk("fault_en_low", 32'(bus.STATE), 32'(ST_FAULT));
        bus.EN = 1'b1;
        bus.CLR_FAULT = 1'b1;
        tick();
        bus.CLR_FAULT = 1'b0;
        chk("clr_fault", 32'(bus.FAULT), 32'd0);
        chk("clr_retry", 32'(bus.RETRY_CNT), 32'd0);
        chk("clr_state", 32'(bus.STATE), 32'd0);

        // Random segments
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: begin
                    locks(1, 1, 1);
                    run($urandom_range(50, 300));
                end
                1: begin
                    repeat ($urandom_range(20, 80)) begin
                        locks($urandom_range(0, 7) != 0,
                              $urandom_range(0, 7) != 0,
                              $urandom_range(0, 7) != 0);
                        tick();
                    end
                end
                2: begin
                    locks(0, $urandom_range(0, 1) != 0, 1);
                    run($urandom_range(50, 200));
                end
                3: begin
                    bus.EN = 1'b0;
                    run($urandom_range(1, 5));
                    bus.EN = 1'b1;
                end
                4: begin
                    bus.CLR_FAULT = 1'b1;
                    tick();
                    bus.CLR_FAULT = 1'b0;
                end
                default: begin
                    RESETN = 1'b0;
                    run($urandom_range(1, 3));
                    RESETN = 1'b1;
                end
            endcase
        end

        // RESETN asserted in READY
        RESETN = 1'b1;
        bus.EN = 1'b1;
        bus.CLR_FAULT = 1'b1;
        tick();
        bus.CLR_FAULT = 1'b0;
        locks(1, 1, 1);
        wait_state(ST_READY, 3000, "final_ready", n);
        RESETN = 1'b0;
        tick();
        chk("rst_state", 32'(bus.STATE), 32'd0);
        chk("rst_ready", 32'(bus.RX_READY), 32'd0);
        chk("rst_rstn", 32'(bus.RX_PCS_RESET_N), 32'd0);
        chk("rst_lol", 32'(bus.LOSS_OF_LOCK), 32'd0);
        chk("rst_retry", 32'(bus.RETRY_CNT), 32'd0);
        chk("rst_fault", 32'(bus.FAULT), 32'd0);
        RESETN = 1'b1;
        run(5);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
